// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
// Two-master to one-slave Wishbone classic arbiter with a slave-stall watchdog.
// m0 is the instruction-fetch master and m1 is the data master. A grant is held
// for as long as the owning master keeps cyc high.
//
// Ports
//   clk, rst_i                 clock, synchronous active-high reset
//   mX_cyc/stb/we/adr/dat/sel  master X request side (X = 0 IF, 1 MEM)
//   mX_ack/err/dat_o           master X response side
//   s_cyc/stb/we/adr/dat/sel_o slave request side
//   s_ack/err/dat_i            slave response side
//   grant_o                    one-hot current owner (bit0 = m0), 0 when idle
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_i,
    // master 0 (instruction fetch)
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_W-1:0]     m0_adr_i,
    input  logic [DATA_W-1:0]     m0_dat_i,
    input  logic [DATA_W/8-1:0]   m0_sel_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic [DATA_W-1:0]     m0_dat_o,
    // master 1 (data)
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_W-1:0]     m1_adr_i,
    input  logic [DATA_W-1:0]     m1_dat_i,
    input  logic [DATA_W/8-1:0]   m1_sel_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [DATA_W-1:0]     m1_dat_o,
    // slave
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    output logic [DATA_W/8-1:0]   s_sel_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic [DATA_W-1:0]     s_dat_i,
    // status
    output logic [1:0]            grant_o
);

    localparam int unsigned SEL_W = DATA_W / 8;
    // Counter only has to reach TIMEOUT; keep at least one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_M0 = 2'd1,
        ST_OWN_M1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;     // 0 = m0 owned last, 1 = m1
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // owner's request signals, selected by state
    logic              own_cyc;
    logic              own_stb;
    logic              own_we;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;
    logic [SEL_W-1:0]  own_sel;

    logic              timeout_c;
    logic              s_cyc_c;
    logic              s_stb_c;
    logic              fwd_ack;
    logic              fwd_err;

    // State, round-robin history and watchdog registers
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE or once the owner has released cyc
    always_comb begin
        state_e arb_win;
        state_d = state_q;
        last_d  = last_q;

        arb_win = ST_IDLE;
        if (m0_cyc_i && m1_cyc_i) begin
            if (PRIO_MODE != 0) begin
                arb_win = ST_OWN_M1;
            end else begin
                arb_win = last_q ? ST_OWN_M0 : ST_OWN_M1;
            end
        end else if (m0_cyc_i) begin
            arb_win = ST_OWN_M0;
        end else if (m1_cyc_i) begin
            arb_win = ST_OWN_M1;
        end

        case (state_q)
            ST_IDLE:   state_d = arb_win;
            ST_OWN_M0: if (!m0_cyc_i) state_d = arb_win;
            ST_OWN_M1: if (!m1_cyc_i) state_d = arb_win;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d == ST_OWN_M0 && state_q != ST_OWN_M0) begin
            last_d = 1'b0;
        end else if (state_d == ST_OWN_M1 && state_q != ST_OWN_M1) begin
            last_d = 1'b1;
        end
    end

    // Owner request mux
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        case (state_q)
            ST_OWN_M0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
                own_sel = m0_sel_i;
            end
            ST_OWN_M1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
                own_sel = m1_sel_i;
            end
            default: ;
        endcase
    end

    // Outputs: routing plus watchdog abort; a same-cycle ack or err beats the abort
    always_comb begin
        timeout_c = 1'b0;
        s_cyc_c   = 1'b0;
        s_stb_c   = 1'b0;
        fwd_ack   = 1'b0;
        fwd_err   = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        m1_dat_o  = '0;
        grant_o   = {state_q == ST_OWN_M1, state_q == ST_OWN_M0};

        if (TIMEOUT != 0) begin
            timeout_c = own_cyc && own_stb && (cnt_q == CNT_LIMIT)
                        && !s_ack_i && !s_err_i;
        end

        s_cyc_c = own_cyc && !timeout_c;
        s_stb_c = own_cyc && own_stb && !timeout_c;

        // Responses after the owner drops cyc belong to an abandoned transfer
        fwd_ack = s_ack_i && s_cyc_c;
        fwd_err = (s_err_i && s_cyc_c) || timeout_c;

        s_cyc_o = s_cyc_c;
        s_stb_o = s_stb_c;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        s_sel_o = own_sel;

        case (state_q)
            ST_OWN_M0: begin
                m0_ack_o = fwd_ack;
                m0_err_o = fwd_err;
                m0_dat_o = s_dat_i;
            end
            ST_OWN_M1: begin
                m1_ack_o = fwd_ack;
                m1_err_o = fwd_err;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    // Watchdog: count stalled strobe cycles, clear on any response, idle strobe or owner change
    always_comb begin
        cnt_d = '0;
        if (TIMEOUT != 0 && state_d == state_q && s_stb_c && !s_ack_i && !s_err_i) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

    typedef logic [140:0] ovec_t;

    typedef struct {
        logic        m0_cyc;
        logic        m0_stb;
        logic [31:0] m0_adr;
        logic        s_ack;
        logic [31:0] s_dat;
        logic [1:0]  e_grant;
        logic        e_scyc;
        logic [31:0] e_sadr;
        logic        e_m0ack;
        logic [31:0] e_m0dat;
        logic        e_m1ack;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        s_ack, s_err;

    // instance A: round-robin, TIMEOUT=4 ; instance B: fixed priority, watchdog off
    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
    logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
    logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
        .m0_dat_o(a_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
        .m1_dat_o(a_m1_dat),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
        .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_ack_i(s_ack), .s_err_i(s_err),
        .s_dat_i(s_dat), .grant_o(a_grant)
    );

    wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
        .m0_dat_o(b_m0_dat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
        .m1_dat_o(b_m1_dat),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
        .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_ack_i(s_ack), .s_err_i(s_err),
        .s_dat_i(s_dat), .grant_o(b_grant)
    );

    ovec_t a_vec, b_vec;
    assign a_vec = {a_grant, a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_s_dat, a_s_sel,
                    a_m0_ack, a_m0_err, a_m0_dat, a_m1_ack, a_m1_err, a_m1_dat};
    assign b_vec = {b_grant, b_s_cyc, b_s_stb, b_s_we, b_s_adr, b_s_dat, b_s_sel,
                    b_m0_ack, b_m0_err, b_m0_dat, b_m1_ack, b_m1_err, b_m1_dat};

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // owner: -1 none, 0 = m0, 1 = m1 ; last: index of the previous owner
    int    owner[2];
    int    last[2];
    int    stall[2];
    bit    model_ok = 1'b0;
    ovec_t exp_vec[2];
    logic  exp_stb[2];

    function automatic bit prio_of(input int i);
        return (i == 1);
    endfunction

    function automatic int tmo_of(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    task automatic model_eval(input int i, output ovec_t v, output logic stb_out);
        logic        cyc, stb, we, abort, sc, ss, ack, err;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [1:0]  g;
        v = '0;
        stb_out = 1'b0;
        if (owner[i] < 0) return;
        if (owner[i] == 0) begin
            cyc = m0_cyc; stb = m0_stb; we = m0_we; adr = m0_adr; dat = m0_dat; sel = m0_sel;
            g = 2'b01;
        end else begin
            cyc = m1_cyc; stb = m1_stb; we = m1_we; adr = m1_adr; dat = m1_dat; sel = m1_sel;
            g = 2'b10;
        end
        abort = (tmo_of(i) > 0) && (stall[i] == tmo_of(i)) && cyc && stb && !s_ack && !s_err;
        sc  = cyc && !abort;
        ss  = cyc && stb && !abort;
        ack = s_ack && sc;
        err = (s_err && sc) || abort;
        if (owner[i] == 0)
            v = {g, sc, ss, we, adr, dat, sel, ack, err, s_dat, 1'b0, 1'b0, 32'h0};
        else
            v = {g, sc, ss, we, adr, dat, sel, 1'b0, 1'b0, 32'h0, ack, err, s_dat};
        stb_out = ss;
    endtask

    task automatic model_step(input int i, input logic ss);
        int nxt;
        if (rst) begin
            owner[i] = -1; last[i] = 1; stall[i] = 0;
            return;
        end
        if (tmo_of(i) > 0 && ss && !s_ack && !s_err)
            stall[i] = (stall[i] < 1000) ? stall[i] + 1 : stall[i];
        else
            stall[i] = 0;
        nxt = owner[i];
        if (owner[i] < 0 || !((owner[i] == 0) ? m0_cyc : m1_cyc)) begin
            if (m0_cyc && m1_cyc) nxt = prio_of(i) ? 1 : 1 - last[i];
            else if (m0_cyc)      nxt = 0;
            else if (m1_cyc)      nxt = 1;
            else                  nxt = -1;
        end
        if (nxt != owner[i]) begin
            stall[i] = 0;
            if (nxt >= 0) last[i] = nxt;
        end
        owner[i] = nxt;
    endtask

    // ---------------- check helpers ----------------
    task automatic chk1(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input ovec_t got, input ovec_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // settle after input change, compare both instances with the model
    task automatic settle();
        #1;
        if (model_ok) begin
            for (int i = 0; i < 2; i++) model_eval(i, exp_vec[i], exp_stb[i]);
            chkv("model_a", a_vec, exp_vec[0]);
            chkv("model_b", b_vec, exp_vec[1]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_ok || rst) begin
            for (int i = 0; i < 2; i++) model_step(i, exp_stb[i]);
            if (rst) model_ok = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat = '0;
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        2'b00, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,        2'b01, 1'b1, 32'h100, 1'b0, 32'h0,        1'b0};
        tbl[3] = '{1'b1, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 2'b01, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0,        2'b01, 1'b0, 32'h100, 1'b0, 32'h0,        1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,        2'b00, 1'b0, 32'h0,   1'b0, 32'h0,        1'b0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) begin settle(); tick(); end
        rst = 1'b0;

        // single m0 read after reset
        for (int r = 0; r < 6; r++) begin
            idle_inputs();
            m0_cyc = tbl[r].m0_cyc; m0_stb = tbl[r].m0_stb; m0_adr = tbl[r].m0_adr;
            s_ack  = tbl[r].s_ack;  s_dat  = tbl[r].s_dat;
            settle();
            chkw("tbl_grant", 32'(a_grant), 32'(tbl[r].e_grant));
            chk1("tbl_s_cyc", a_s_cyc, tbl[r].e_scyc);
            chkw("tbl_s_adr", a_s_adr, tbl[r].e_sadr);
            chk1("tbl_m0_ack", a_m0_ack, tbl[r].e_m0ack);
            chkw("tbl_m0_dat", a_m0_dat, tbl[r].e_m0dat);
            chk1("tbl_m1_ack", a_m1_ack, tbl[r].e_m1ack);
            tick();
        end

        // repeated ties from reset: A alternates starting with m0, B always m1
        idle_inputs(); rst = 1'b1; settle(); tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h200 + k;
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h300 + k;
            settle(); tick();
            s_ack = 1'b1; s_dat = 32'h1000 + k;
            settle();
            chkw("rr_grant", 32'(a_grant), (k % 2 == 0) ? 32'h1 : 32'h2);
            chkw("fp_grant", 32'(b_grant), 32'h2);
            chk1("rr_win_ack", (k % 2 == 0) ? a_m0_ack : a_m1_ack, 1'b1);
            chk1("rr_lose_ack", (k % 2 == 0) ? a_m1_ack : a_m0_ack, 1'b0);
            tick();
            idle_inputs();
            settle(); tick();
        end

        // m0 holds cyc for 5 beats while m1 waits: no preemption, then handover gap
        idle_inputs();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h400;
        settle(); tick();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h500;
        m1_dat = 32'hCAFE0001; m1_sel = 4'hF;
        for (int b = 0; b < 5; b++) begin
            s_ack = 1'b1; s_dat = 32'hA0 + b;
            settle();
            chkw("hold_grant_a", 32'(a_grant), 32'h1);
            chkw("hold_grant_b", 32'(b_grant), 32'h1);
            chk1("hold_m0_ack", a_m0_ack, 1'b1);
            chk1("hold_m1_ack", a_m1_ack, 1'b0);
            tick();
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
        settle();
        chk1("handover_gap_cyc", a_s_cyc, 1'b0);
        chkw("handover_gap_grant", 32'(a_grant), 32'h1);
        tick();

        // m1 stalls: abort on 5th stalled cycle, then ack on the exact timeout cycle wins
        for (int c = 0; c < 10; c++) begin
            s_ack = (c == 9);
            settle();
            chkw("wd_grant", 32'(a_grant), 32'h2);
            chkw("wd_s_adr", a_s_adr, 32'h500);
            chk1("wd_m1_err", a_m1_err, (c == 4));
            chk1("wd_s_stb", a_s_stb, (c != 4));
            chk1("wd_off_err", b_m1_err, 1'b0);
            if (c == 9) chk1("wd_ack_wins", a_m1_ack, 1'b1);
            tick();
        end

        // reset with m1's strobe pending
        s_ack = 1'b0; rst = 1'b1;
        settle(); tick();
        rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1; s_dat = 32'h12345678;
        settle();
        chkv("rst_zero_a", a_vec, '0);
        chkv("rst_zero_b", b_vec, '0);
        tick();
        s_ack = 1'b0;
        settle();
        chkw("post_rst_tie_a", 32'(a_grant), 32'h1);
        chkw("post_rst_tie_b", 32'(b_grant), 32'h2);
        tick();
        idle_inputs();
        settle(); tick();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
            m0_stb = ($urandom_range(0, 3) != 0);
            m1_stb = ($urandom_range(0, 3) != 0);
            m0_we  = 1'($urandom); m1_we = 1'($urandom);
            m0_adr = $urandom; m1_adr = $urandom;
            m0_dat = $urandom; m1_dat = $urandom;
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            s_ack  = ($urandom_range(0, 3) == 0);
            s_err  = ($urandom_range(0, 19) == 0);
            s_dat  = $urandom;
            rst    = ($urandom_range(0, 199) == 0);
            settle(); tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
